// File: rtl/wbm.sv
// wbm: write-back/memory stage; retires ALU results, pulses branch redirects,
// and performs one pipelined Wishbone load/store at a time with lane steering.
// Ports: clk_i/rst_i (async, active-low); input_* valid/ready from exm;
// reg_* register-file write; branch_* redirect; wb_* data bus;
// bus_error_o timeout pulse; misaligned_o trap pulse.
// Optional: WBM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module wbm #(
  parameter int MEM_TIMEOUT = 255,
  parameter bit ZERO_REG_WR = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic        result_write_i,
  input  logic [4:0]  result_addr_i,
  input  logic [31:0] result_i,
  input  logic        branch_i,
  input  logic [19:0] branch_offset_i,
  input  logic        ls_load_i,
  input  logic        ls_store_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_unsigned_i,
  input  logic [31:0] ls_data_i,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic        branch_o,
  output logic [19:0] branch_offset_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  output logic        bus_error_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic        acc, is_ls, mis, start, wr_ok;
  logic        hit, done, tmo;
  logic        ld_q, uns_q, wr_q;
  logic [1:0]  size_q, lane_q;
  logic [4:0]  rd_q;
  logic [3:0]  sel;
  logic [31:0] rep, ext;
  logic [7:0]  b;
  logic [15:0] h;

  assign input_ready_o = (state == IDLE);
  assign acc   = input_valid_i & input_ready_o;
  assign is_ls = ls_load_i | ls_store_i;
  assign wr_ok = result_write_i & (ZERO_REG_WR | (result_addr_i != 5'd0));

`ifdef WBM_MISALIGN_TRAP_EN
  assign mis = ((ls_size_i == 2'b01) && result_i[0]) ||
               (ls_size_i[1] && (result_i[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign start = acc & is_ls & ~mis;
  // Counter value k means k+1 cycles spent in REQ/WAIT so far.
  assign hit   = (cnt == TMO_LAST);

  always_comb begin
    sel = 4'b1111;
    rep = ls_data_i;
    case (ls_size_i)
      2'b00: begin
        sel = 4'b0001 << result_i[1:0];
        rep = {4{ls_data_i[7:0]}};
      end
      2'b01: begin
        sel = result_i[1] ? 4'b1100 : 4'b0011;
        rep = {2{ls_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    b = wb_dat_i[31:24];
    case (lane_q)
      2'd0:    b = wb_dat_i[7:0];
      2'd1:    b = wb_dat_i[15:8];
      2'd2:    b = wb_dat_i[23:16];
      default: b = wb_dat_i[31:24];
    endcase
    h = lane_q[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
    ext = wb_dat_i;
    case (size_q)
      2'b00:   ext = uns_q ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   ext = uns_q ? {16'd0, h} : {{16{h[15]}}, h};
      default: ext = wb_dat_i;
    endcase
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = REQ;
      REQ: begin
        if (!wb_stall_i && wb_ack_i) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (hit) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end else if (!wb_stall_i) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (wb_ack_i) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (hit) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              cnt <= '0;
    else if (start)          cnt <= '0;
    else if (state != IDLE)  cnt <= cnt + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      ld_q     <= 1'b0;
      uns_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      lane_q   <= '0;
      rd_q     <= '0;
    end else begin
      wb_cyc_o <= (state_n != IDLE);
      wb_stb_o <= (state_n == REQ);
      if (start) begin
        wb_adr_o <= {result_i[31:2], 2'b00};
        wb_dat_o <= rep;
        wb_we_o  <= ls_store_i;
        wb_sel_o <= sel;
        ld_q     <= ls_load_i;
        uns_q    <= ls_unsigned_i;
        wr_q     <= wr_ok;
        size_q   <= ls_size_i;
        lane_q   <= result_i[1:0];
        rd_q     <= result_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_o     <= 1'b0;
      reg_addr_o      <= '0;
      reg_data_o      <= '0;
      branch_o        <= 1'b0;
      branch_offset_o <= '0;
      bus_error_o     <= 1'b0;
      misaligned_o    <= 1'b0;
    end else begin
      reg_write_o  <= (acc & ~is_ls & wr_ok) | (done & ld_q & wr_q);
      branch_o     <= acc & branch_i;
      bus_error_o  <= tmo;
      misaligned_o <= acc & is_ls & mis;
      if (acc) branch_offset_o <= branch_offset_i;
      if (acc && !is_ls) begin
        reg_addr_o <= result_addr_i;
        reg_data_o <= result_i;
      end else if (done && ld_q) begin
        reg_addr_o <= rd_q;
        reg_data_o <= ext;
      end
    end
  end

endmodule

// File: tb/tb_wbm.sv
// tb_wbm: directed and randomized checks of wbm against a small reference
// model of retire, lane steering, load extension and bus timeout.
module tb_wbm;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        input_valid_i;
  logic        input_ready_o;
  logic        result_write_i;
  logic [4:0]  result_addr_i;
  logic [31:0] result_i;
  logic        branch_i;
  logic [19:0] branch_offset_i;
  logic        ls_load_i;
  logic        ls_store_i;
  logic [1:0]  ls_size_i;
  logic        ls_unsigned_i;
  logic [31:0] ls_data_i;
  logic        reg_write_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o;
  logic        branch_o;
  logic [19:0] branch_offset_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_stall_i;
  logic        wb_ack_i;
  logic        bus_error_o;
  logic        misaligned_o;

  int errors = 0;
  int checks = 0;

  wbm #(.MEM_TIMEOUT(8), .ZERO_REG_WR(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
    .result_write_i(result_write_i), .result_addr_i(result_addr_i),
    .result_i(result_i), .branch_i(branch_i),
    .branch_offset_i(branch_offset_i),
    .ls_load_i(ls_load_i), .ls_store_i(ls_store_i),
    .ls_size_i(ls_size_i), .ls_unsigned_i(ls_unsigned_i),
    .ls_data_i(ls_data_i),
    .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
    .reg_data_o(reg_data_o), .branch_o(branch_o),
    .branch_offset_o(branch_offset_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i),
    .bus_error_o(bus_error_o), .misaligned_o(misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    input_valid_i   = 1'b0;
    result_write_i  = 1'b0;
    result_addr_i   = '0;
    result_i        = '0;
    branch_i        = 1'b0;
    branch_offset_i = '0;
    ls_load_i       = 1'b0;
    ls_store_i      = 1'b0;
    ls_size_i       = '0;
    ls_unsigned_i   = 1'b0;
    ls_data_i       = '0;
  endtask

  // One ALU instruction accepted, outputs checked at acceptance+1.
  task automatic alu(input logic [4:0] rd, input logic [31:0] res,
                     input logic wr, input logic br,
                     input logic [19:0] off, input logic last);
    logic exp_wr;
    input_valid_i   = 1'b1;
    result_write_i  = wr;
    result_addr_i   = rd;
    result_i        = res;
    branch_i        = br;
    branch_offset_i = off;
    step();
    if (last) idle_inputs();
    exp_wr = wr && (rd != 5'd0);
    chk("alu_wr", reg_write_o, exp_wr);
    if (exp_wr) begin
      chk("alu_addr", reg_addr_o, rd);
      chk("alu_data", reg_data_o, res);
    end
    chk("alu_br", branch_o, br);
    if (br) chk("alu_off", branch_offset_o, off);
  endtask

  // Full load/store with a slave that stalls, then acks after ackdly
  // WAIT cycles (0 = ack in the cycle the request is taken).
  task automatic access(input logic ld, input logic [31:0] a,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] sdata, input logic [4:0] rd,
                        input logic [31:0] word, input int stalls,
                        input int ackdly);
    logic [3:0]  esel;
    logic [31:0] edat, v;
    int sh, st, wd, nstb;
    logic got, rw, berr, cyc_after;
    logic [31:0] rdat;
    logic [4:0]  raddr;
    esel = (sz == 2'd0) ? 4'(1 << (a % 4)) :
           (sz == 2'd1) ? 4'(3 << (a & 2)) : 4'hF;
    edat = (sz == 2'd0) ? (sdata & 32'hFF) * 32'h0101_0101 :
           (sz == 2'd1) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
    sh = (sz == 2'd0) ? 8 * int'(a % 4) :
         (sz == 2'd1) ? 8 * int'(a & 2) : 0;
    v = word >> sh;
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    input_valid_i  = 1'b1;
    ls_load_i      = ld;
    ls_store_i     = !ld;
    result_i       = a;
    ls_size_i      = sz;
    ls_unsigned_i  = uns;
    ls_data_i      = sdata;
    result_write_i = ld;
    result_addr_i  = rd;
    step();
    idle_inputs();
    chk("acc_ready", input_ready_o, 1'b0);
    chk("acc_cyc", wb_cyc_o, 1'b1);
    chk("acc_adr", wb_adr_o, a & 32'hFFFF_FFFC);
    chk("acc_sel", wb_sel_o, esel);
    chk("acc_we", wb_we_o, !ld);
    if (!ld) chk("acc_dat", wb_dat_o, edat);
    st = stalls; wd = -1; nstb = 0; got = 0;
    rw = 0; berr = 0; cyc_after = 1; rdat = '0; raddr = '0;
    for (int i = 0; i < 30 && wb_cyc_o && !got; i++) begin
      wb_stall_i = 1'b0;
      wb_ack_i   = 1'b0;
      if (wb_stb_o) begin
        nstb++;
        if (st > 0) begin
          wb_stall_i = 1'b1;
          st--;
        end else if (ackdly == 0) begin
          wb_ack_i = 1'b1;
        end else begin
          wd = ackdly;
        end
      end else begin
        wd--;
        if (wd == 0) wb_ack_i = 1'b1;
      end
      wb_dat_i = wb_ack_i ? word : $urandom;
      step();
      if (wb_ack_i) begin
        got = 1; rw = reg_write_o; rdat = reg_data_o;
        raddr = reg_addr_o; berr = bus_error_o; cyc_after = wb_cyc_o;
      end
    end
    wb_stall_i = 1'b0;
    wb_ack_i   = 1'b0;
    chk("acc_ack_seen", got, 1'b1);
    chk("acc_stb_cycles", nstb, stalls + 1);
    chk("acc_cyc_drop", cyc_after, 1'b0);
    chk("acc_no_err", berr, 1'b0);
    chk("acc_rw", rw, ld && (rd != 5'd0));
    if (ld && rd != 5'd0) begin
      chk("acc_rd", raddr, rd);
      chk("acc_data", rdat, v);
    end
    chk("acc_ready_back", input_ready_o, 1'b1);
    step();
    chk("acc_rw_pulse", reg_write_o, 1'b0);
  endtask

  initial begin
    int k;
    logic [31:0] a;
    logic [1:0]  sz;
    idle_inputs();
    wb_dat_i = '0; wb_stall_i = 1'b0; wb_ack_i = 1'b0;
    rst_i = 1'b0;
    step(); step();
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_rw", reg_write_o, 1'b0);
    chk("rst_br", branch_o, 1'b0);
    chk("rst_err", bus_error_o, 1'b0);
    chk("rst_mis", misaligned_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'd0);
    rst_i = 1'b1;
    step();
    chk("rst_ready", input_ready_o, 1'b1);

    alu(5'd5, 32'h1234_5678, 1'b1, 1'b0, 20'd0, 1'b1);
    step();
    chk("alu_pulse", reg_write_o, 1'b0);
    alu(5'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 20'h00040, 1'b1);
    step();
    chk("br_pulse", branch_o, 1'b0);
    alu(5'd7, 32'h0000_0001, 1'b1, 1'b0, 20'd0, 1'b0);
    alu(5'd8, 32'h0000_0002, 1'b1, 1'b0, 20'd0, 1'b0);
    alu(5'd9, 32'h0000_0003, 1'b0, 1'b1, 20'hABCDE, 1'b1);

    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk("idle_ack_rw", reg_write_o, 1'b0);
    chk("idle_ack_cyc", wb_cyc_o, 1'b0);

    access(1'b1, 32'h103, 2'd0, 1'b0, 0, 5'd3, 32'h8012_3456, 2, 0);
    access(1'b1, 32'h103, 2'd0, 1'b1, 0, 5'd3, 32'h8012_3456, 2, 0);
    access(1'b0, 32'h202, 2'd1, 1'b0, 32'hBEEF, 5'd0, 0, 0, 1);
    access(1'b1, 32'h206, 2'd1, 1'b0, 0, 5'd4, 32'h9ABC_0000, 0, 1);
    access(1'b1, 32'h300, 2'd3, 1'b0, 0, 5'd6, 32'hCAFE_F00D, 1, 2);
    access(1'b1, 32'h400, 2'd2, 1'b0, 0, 5'd10, 32'h1111_2222, 0, 7);

`ifdef WBM_MISALIGN_TRAP_EN
    input_valid_i = 1'b1; ls_load_i = 1'b1; result_write_i = 1'b1;
    result_addr_i = 5'd2; result_i = 32'h101; ls_size_i = 2'd2;
    step();
    idle_inputs();
    chk("mis_pulse", misaligned_o, 1'b1);
    chk("mis_cyc", wb_cyc_o, 1'b0);
    chk("mis_rw", reg_write_o, 1'b0);
    chk("mis_ready", input_ready_o, 1'b1);
    step();
    chk("mis_once", misaligned_o, 1'b0);
`else
    access(1'b1, 32'h101, 2'd2, 1'b0, 0, 5'd2, 32'h7654_3210, 0, 1);
    chk("mis_tied", misaligned_o, 1'b0);
`endif

    input_valid_i = 1'b1; ls_load_i = 1'b1; result_write_i = 1'b1;
    result_addr_i = 5'd1; result_i = 32'h500; ls_size_i = 2'd2;
    step();
    idle_inputs();
    chk("tmo_start", wb_cyc_o, 1'b1);
    k = 0;
    while (wb_cyc_o && k < 20) begin
      step();
      k++;
    end
    chk("tmo_cycles", k, 8);
    chk("tmo_err", bus_error_o, 1'b1);
    chk("tmo_rw", reg_write_o, 1'b0);
    chk("tmo_stb", wb_stb_o, 1'b0);
    chk("tmo_ready", input_ready_o, 1'b1);
    step();
    chk("tmo_pulse", bus_error_o, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        alu(5'($urandom), $urandom, 1'($urandom), 1'($urandom),
            20'($urandom), 1'b1);
      end else begin
        a  = 32'h1000 + 32'($urandom_range(0, 255));
        sz = 2'($urandom);
`ifdef WBM_MISALIGN_TRAP_EN
        if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
        if (sz[1]) a = a & 32'hFFFF_FFFC;
`endif
        access(1'($urandom), a, sz, 1'($urandom), $urandom,
               5'($urandom), $urandom, $urandom_range(0, 2),
               $urandom_range(0, 3));
      end
    end

    input_valid_i = 1'b1; ls_load_i = 1'b1; result_write_i = 1'b1;
    result_addr_i = 5'd1; result_i = 32'h600; ls_size_i = 2'd2;
    step();
    idle_inputs();
    step();
    chk("rst_wait_cyc", wb_cyc_o, 1'b1);
    chk("rst_wait_stb", wb_stb_o, 1'b0);
    rst_i = 1'b0;
    #1;
    chk("rst_async_cyc", wb_cyc_o, 1'b0);
    step();
    rst_i = 1'b1;
    step();
    chk("rst_rel_ready", input_ready_o, 1'b1);
    chk("rst_rel_cyc", wb_cyc_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
